mon_exp: RTL and testbench
==========================

// Module: mon_exp
// PURPOSE
//   Montgomery modular-exponentiation sequencer: computes RESULT = X^E mod M by driving one external
//   MonMult instance through left-to-right square-and-multiply, then one conversion out of the
//   Montgomery domain. Sits directly upstream of MonMult and is its sole driver. Host/APB logic
//   precomputes the Montgomery-domain operands XBAR and RMOD (R = 2^W).
// PARAMETERS
//   W      64  operand width; must equal MonMult operand width
//   EXP_W  64  exponent width; bits are scanned MSB first
// PORTS
//   pclk      in   1      clock; all logic on posedge
//   reset     in   1      asynchronous, active-high reset
//   start     in   1      begin operation; sampled only in IDLE
//   xbar      in   W      X*R mod M (Montgomery-domain base)
//   rmod      in   W      R mod M (Montgomery-domain one)
//   e         in   EXP_W  exponent
//   m         in   W      odd modulus, m > 1
//   busy      out  1      high from cycle after accepted start through DONE
//   done      out  1      one-cycle pulse; result valid from this cycle on
//   result    out  W      X^E mod M; held until next accepted start
//   mm_go     out  1      to MonMult GO
//   mm_a      out  W      to MonMult A
//   mm_b      out  W      to MonMult B
//   mm_m      out  W      to MonMult M
//   mm_p      in   W      from MonMult P
//   mm_ready  in   1      from MonMult is_ready
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, done=0, result=0, mm_go=0, internal acc/e/x/m regs and bit index 0.
//     Reset mid-operation aborts immediately; mm_go dropping clears the multiplier.
//   - start in IDLE: latch xbar, rmod->acc, e, m; bit index i=EXP_W-1; go to SQR. start outside IDLE ignored.
//   - mm_m driven from latched m at all times; mm_a/mm_b registered, stable for whole time mm_go=1.
//   - States:
//     IDLE  : busy=0, mm_go=0.
//     SQR   : mm_a=mm_b=acc, mm_go=1. On mm_ready=1: acc<=mm_p, mm_go<=0, go GAP; next op = MUL if
//             e[i]=1, else (i==0 ? CONV : SQR with i<=i-1).
//     MUL   : mm_a=acc, mm_b=xbar, mm_go=1. On mm_ready: acc<=mm_p, mm_go<=0, GAP; next op =
//             (i==0 ? CONV : SQR with i<=i-1).
//     CONV  : mm_a=acc, mm_b=1, mm_go=1. On mm_ready: result<=mm_p, mm_go<=0, go DONE.
//     GAP   : exactly one cycle with mm_go=0 (resets MonMult), then enter the pending op state.
//     DONE  : done=1 for one cycle, busy=0 next cycle, return to IDLE.
//   - mm_ready is ignored in every cycle where mm_go=0 and in the first cycle of each op (stale-ready guard).
//   - Op count: EXP_W squares + popcount(e) multiplies + 1 conversion; no leading-zero skip
//     (constant square count). Latency start->done = sum over ops of (cycles mm_go high) + one GAP per op.
//   - e=0: all squares of RMOD stay RMOD, CONV yields 1 -> result=1.
//   - No width growth: all values stay W bits; MonMult output assumed < m.
// TESTING
//   1. m=13, rmod=3, xbar=6 (X=2), e=10 -> done pulse, result=10; exactly 64+2+1 MonMult GO pulses.
//   2. m=13, rmod=3, xbar=6, e=0 -> result=1; 65 GO pulses, no MUL state entered.
//   3. m=0xFFFFFFFFFFFFFFC5, X=5 (bench computes xbar,rmod), e=1 -> result=5.
//   4. Fermat: same m, X=3, e=m-1 -> result=1; busy high continuously until done.
//   5. start re-pulsed while busy with different operands -> ignored; result matches first operands.
//   6. reset asserted mid-SQR -> same edge: busy=0, mm_go=0, result=0; next start runs case 1 cleanly.

Source files
------------

// File: rtl/mon_exp.sv
// Montgomery modular-exponentiation sequencer: drives one external MonMult through
// left-to-right square-and-multiply over every exponent bit, then converts the result out of the Montgomery domain.
module mon_exp #(
    parameter int W     = 64,
    parameter int EXP_W = 64
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     xbar,
    input  logic [W-1:0]     rmod,
    input  logic [EXP_W-1:0] e,
    input  logic [W-1:0]     m,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             mm_go,
    output logic [W-1:0]     mm_a,
    output logic [W-1:0]     mm_b,
    output logic [W-1:0]     mm_m,
    input  logic [W-1:0]     mm_p,
    input  logic             mm_ready
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        MUL  = 3'd2,
        CONV = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state;
    state_t           pend;
    logic [W-1:0]     acc;
    logic [W-1:0]     xr;
    logic [W-1:0]     mr;
    logic [EXP_W-1:0] er;
    logic [IW-1:0]    idx;
    logic             first;
    logic             accept;
    logic             last_bit;
    state_t           after_bit;

    assign mm_m = mr;

    // A ready seen in the first cycle of an op may be left over from the previous product.
    assign accept    = mm_go && mm_ready && !first;
    assign last_bit  = (idx == '0);
    assign after_bit = last_bit ? CONV : SQR;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            mm_go  <= 1'b0;
            mm_a   <= '0;
            mm_b   <= '0;
            acc    <= '0;
            xr     <= '0;
            mr     <= '0;
            er     <= '0;
            idx    <= '0;
            first  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= xbar;
                        acc   <= rmod;
                        er    <= e;
                        mr    <= m;
                        idx   <= IW'(EXP_W - 1);
                        mm_a  <= rmod;
                        mm_b  <= rmod;
                        mm_go <= 1'b1;
                        first <= 1'b1;
                        busy  <= 1'b1;
                        state <= SQR;
                    end
                end
                SQR: begin
                    first <= 1'b0;
                    if (accept) begin
                        acc   <= mm_p;
                        mm_go <= 1'b0;
                        state <= GAP;
                        if (er[idx]) begin
                            pend <= MUL;
                        end else begin
                            pend <= after_bit;
                            if (!last_bit) idx <= idx - 1'b1;
                        end
                    end
                end
                MUL: begin
                    first <= 1'b0;
                    if (accept) begin
                        acc   <= mm_p;
                        mm_go <= 1'b0;
                        state <= GAP;
                        pend  <= after_bit;
                        if (!last_bit) idx <= idx - 1'b1;
                    end
                end
                CONV: begin
                    first <= 1'b0;
                    if (accept) begin
                        result <= mm_p;
                        mm_go  <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                GAP: begin
                    // The single low cycle of mm_go clears the multiplier before the next op.
                    state <= pend;
                    mm_go <= 1'b1;
                    first <= 1'b1;
                    mm_a  <= acc;
                    if (pend == MUL)       mm_b <= xr;
                    else if (pend == CONV) mm_b <= W'(1);
                    else                   mm_b <= acc;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_exp.sv
// Self-checking bench for mon_exp: a behavioural MonMult with random latency and stale-ready
// injection, checked against a direct modular-exponentiation reference.
module tb_mon_exp;

    localparam int W = 64;

    logic         pclk;
    logic         reset;
    logic         start;
    logic [W-1:0] xbar;
    logic [W-1:0] rmod;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         mm_go;
    logic [W-1:0] mm_a;
    logic [W-1:0] mm_b;
    logic [W-1:0] mm_m;
    logic [W-1:0] mm_p;
    logic         mm_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mon_exp #(.W(W), .EXP_W(W)) dut (
        .pclk(pclk), .reset(reset), .start(start), .xbar(xbar), .rmod(rmod), .e(e), .m(m),
        .busy(busy), .done(done), .result(result), .mm_go(mm_go), .mm_a(mm_a), .mm_b(mm_b),
        .mm_m(mm_m), .mm_p(mm_p), .mm_ready(mm_ready)
    );

    // clock / reset
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // reference arithmetic
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] t;
        t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, n};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] powmod(input logic [W-1:0] x, input logic [W-1:0] ex,
                                            input logic [W-1:0] n);
        logic [W-1:0] r;
        r = W'(1) % n;
        for (int i = W - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (ex[i]) r = mulmod(r, x, n);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] n);
        logic [2*W-1:0] t;
        t = {x, {W{1'b0}}} % {{W{1'b0}}, n};
        return t[W-1:0];
    endfunction

    // a*b*2^-W mod n, bit-serial
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, n};
            t = t >> 1;
        end
        if (t >= {2'b00, n}) t = t - {2'b00, n};
        return t[W-1:0];
    endfunction

    // behavioural MonMult
    int fix_lat    = 0;
    bit stale_mode = 0;
    int lat;
    int cnt;
    bit held;

    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            mm_ready <= 1'b0;
            mm_p     <= '0;
            cnt      <= 0;
            lat      <= 0;
            held     <= 1'b0;
        end else if (!mm_go) begin
            cnt <= 0;
            lat <= (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
            if (stale_mode && mm_ready && !held) begin
                held <= 1'b1;
            end else begin
                mm_ready <= 1'b0;
                held     <= 1'b0;
            end
        end else begin
            held <= 1'b0;
            if (cnt >= lat) begin
                mm_ready <= 1'b1;
                mm_p     <= mont(mm_a, mm_b, mm_m);
            end else begin
                mm_ready <= 1'b0;
                cnt      <= cnt + 1;
            end
        end
    end

    // bus monitor: op count, operand stability, modulus routing
    int           go_cnt   = 0;
    int           nsq_cnt  = 0;
    int           stab_err = 0;
    int           mm_err   = 0;
    bit           go_prev  = 1'b0;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;
    logic [W-1:0] run_m;

    always @(negedge pclk) begin
        if (mm_go && !go_prev) begin
            go_cnt++;
            cap_a = mm_a;
            cap_b = mm_b;
            if (mm_a != mm_b) nsq_cnt++;
        end else if (mm_go && (mm_a !== cap_a || mm_b !== cap_b)) begin
            stab_err++;
        end
        if (mm_go && mm_m !== run_m) mm_err++;
        go_prev = mm_go;
    end

    // driver
    logic [W-1:0] last_res;
    int           last_cycles;
    int           last_go;
    int           last_nsq;
    int           last_bad;
    bit           last_timeout;
    bit           last_busy_drop;
    bit           last_done_busy;
    bit           last_done_after;
    bit           last_busy_after;

    task automatic run_op(input logic [W-1:0] xb, input logic [W-1:0] rm, input logic [W-1:0] ee,
                          input logic [W-1:0] mm, input int poke);
        int g0, n0, s0, k0;
        @(negedge pclk);
        xbar = xb; rmod = rm; e = ee; m = mm; run_m = mm; start = 1'b1;
        g0 = go_cnt; n0 = nsq_cnt; s0 = stab_err; k0 = mm_err;
        last_cycles = 0; last_timeout = 1'b1; last_busy_drop = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge pclk);
            start = 1'b0;
            last_cycles++;
            if (done) begin
                last_timeout = 1'b0;
                break;
            end
            if (!busy) last_busy_drop = 1'b1;
            if (last_cycles == poke) begin
                xbar = 64'd7; rmod = 64'd5; e = '1; m = 64'd101; start = 1'b1;
            end
        end
        last_res       = result;
        last_done_busy = busy;
        @(negedge pclk);
        last_done_after = done;
        last_busy_after = busy;
        last_go  = go_cnt - g0;
        last_nsq = nsq_cnt - n0;
        last_bad = (stab_err - s0) + (mm_err - k0);
        if (last_timeout) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout: no done within 5000 cycles");
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; xbar = '0; rmod = '0; e = '0; m = 64'd3;
        repeat (3) @(negedge pclk);
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (mm_go !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %0b want 0", mm_go); end
        n_tests++; if (result !== '0)  begin n_fail++; $display("FAIL reset_result: got %0h want 0", result); end
        reset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_basic();
        fix_lat = 0; stale_mode = 0;
        run_op(64'd6, 64'd3, 64'd10, 64'd13, 0);
        n_tests++; if (last_res !== 64'd10) begin n_fail++; $display("FAIL basic_result: got %0d want 10", last_res); end
        n_tests++; if (last_go != 67) begin n_fail++; $display("FAIL basic_go_pulses: got %0d want 67", last_go); end
        n_tests++; if (last_cycles != 201) begin n_fail++; $display("FAIL basic_latency: got %0d want 201", last_cycles); end
        n_tests++; if (last_done_busy !== 1'b1 || last_busy_drop) begin
            n_fail++; $display("FAIL basic_busy: done_busy %0b drop %0b want 1 0", last_done_busy, last_busy_drop); end
        n_tests++; if (last_done_after !== 1'b0 || last_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse: done %0b busy %0b after want 0 0", last_done_after, last_busy_after); end
        n_tests++; if (result !== 64'd10) begin n_fail++; $display("FAIL basic_hold: got %0d want 10", result); end
        n_tests++; if (last_bad != 0) begin n_fail++; $display("FAIL basic_bus: got %0d bus errors want 0", last_bad); end
    endtask

    task automatic test_zero_exp();
        fix_lat = -1; stale_mode = 0;
        run_op(64'd6, 64'd3, 64'd0, 64'd13, 0);
        n_tests++; if (last_res !== 64'd1) begin n_fail++; $display("FAIL zero_result: got %0d want 1", last_res); end
        n_tests++; if (last_go != 65) begin n_fail++; $display("FAIL zero_go_pulses: got %0d want 65", last_go); end
        n_tests++; if (last_nsq != 1) begin n_fail++; $display("FAIL zero_non_square_ops: got %0d want 1", last_nsq); end
    endtask

    task automatic test_wide();
        logic [W-1:0] mw;
        mw = 64'hFFFF_FFFF_FFFF_FFC5;
        fix_lat = -1; stale_mode = 1;
        run_op(to_mont(64'd5, mw), to_mont(64'd1, mw), 64'd1, mw, 0);
        n_tests++; if (last_res !== 64'd5) begin n_fail++; $display("FAIL wide_result: got %0h want 5", last_res); end
        n_tests++; if (last_go != 66) begin n_fail++; $display("FAIL wide_go_pulses: got %0d want 66", last_go); end
    endtask

    task automatic test_fermat();
        logic [W-1:0] mw;
        mw = 64'hFFFF_FFFF_FFFF_FFC5;
        fix_lat = -1; stale_mode = 1;
        run_op(to_mont(64'd3, mw), to_mont(64'd1, mw), mw - 1, mw, 0);
        n_tests++; if (last_res !== 64'd1) begin n_fail++; $display("FAIL fermat_result: got %0h want 1", last_res); end
        n_tests++; if (last_busy_drop) begin n_fail++; $display("FAIL fermat_busy: dropped before done, want continuous"); end
        n_tests++; if (last_go != 65 + $countones(mw - 1)) begin
            n_fail++; $display("FAIL fermat_go_pulses: got %0d want %0d", last_go, 65 + $countones(mw - 1)); end
        n_tests++; if (last_bad != 0) begin n_fail++; $display("FAIL fermat_bus: got %0d bus errors want 0", last_bad); end
    endtask

    task automatic test_ignore_start();
        fix_lat = 1; stale_mode = 0;
        run_op(64'd6, 64'd3, 64'd10, 64'd13, 20);
        n_tests++; if (last_res !== 64'd10) begin n_fail++; $display("FAIL restart_result: got %0d want 10", last_res); end
        n_tests++; if (last_go != 67) begin n_fail++; $display("FAIL restart_go_pulses: got %0d want 67", last_go); end
        n_tests++; if (last_bad != 0) begin n_fail++; $display("FAIL restart_bus: got %0d bus errors want 0", last_bad); end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        fix_lat = 3; stale_mode = 0;
        @(negedge pclk);
        xbar = 64'd6; rmod = 64'd3; e = 64'd10; m = 64'd13; run_m = 64'd13; start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        @(negedge pclk);
        n_tests++; if (mm_go !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_running: go %0b busy %0b want 1 1", mm_go, busy); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_busy: got %0b want 0", busy); end
        n_tests++; if (mm_go !== 1'b0) begin n_fail++; $display("FAIL mid_reset_go: got %0b want 0", mm_go); end
        n_tests++; if (result !== '0)  begin n_fail++; $display("FAIL mid_reset_result: got %0h want 0", result); end
        @(negedge pclk);
        reset = 1'b0;
        fix_lat = 0;
        run_op(64'd6, 64'd3, 64'd10, 64'd13, 0);
        n_tests++; if (last_res !== 64'd10) begin n_fail++; $display("FAIL mid_rerun_result: got %0d want 10", last_res); end
        n_tests++; if (last_go != 67 || last_cycles != 201) begin
            n_fail++; $display("FAIL mid_rerun_timing: go %0d cycles %0d want 67 201", last_go, last_cycles); end
    endtask

    task automatic test_random();
        logic [W-1:0] mr, xr, er, exp_r;
        logic [W-1:0] exp_q[$];
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) mr = {$urandom, $urandom} | 64'd1;
            else            mr = 64'($urandom_range(3, 5000)) | 64'd1;
            xr = {$urandom, $urandom} % mr;
            er = {$urandom, $urandom};
            if (t == 5) er = 64'h8000_0000_0000_0001;
            fix_lat = -1; stale_mode = ($urandom_range(0, 1) == 1);
            exp_q.push_back(powmod(xr, er, mr));
            run_op(to_mont(xr, mr), to_mont(64'd1, mr), er, mr, 0);
            exp_r = exp_q.pop_front();
            n_tests++; if (last_res !== exp_r) begin
                n_fail++; $display("FAIL rand_result[%0d]: got %0h want %0h", t, last_res, exp_r); end
            n_tests++; if (last_go != 65 + $countones(er) || last_bad != 0) begin
                n_fail++; $display("FAIL rand_ops[%0d]: go %0d bus errors %0d want %0d 0", t, last_go, last_bad, 65 + $countones(er)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_exp();
        test_wide();
        test_fermat();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
